// File: rtl/cb_shift_seq.sv
// cb_shift_seq: sequences a CB-prefix shift/rotate (RLC RRC RL RR SLA SRA SRL SWAP) over two ALU cycles
// Ports: clk, nreset (sync, active-low); req/req_op/req_b/req_c in, ack out;
//   alu_busy stalls the sequence; alu_op/alu_si/alu_sh/alu_oe/alu_ld/alu_l/alu_h drive the ALU;
//   alu_shift_dbh/alu_shift_dbl/alu_result/alu_zero come back from it;
//   done pulses for one cycle with res and flags {Z,N,H,C}.
module cb_shift_seq #(
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req,
  input  logic [2:0] req_op,
  input  logic [7:0] req_b,
  input  logic       req_c,
  output logic       ack,
  input  logic       alu_busy,
  output logic [7:0] alu_op,
  output logic       alu_si,
  output logic [1:0] alu_sh,
  output logic [1:0] alu_oe,
  output logic       alu_ld,
  output logic       alu_l,
  output logic       alu_h,
  input  logic       alu_shift_dbh,
  input  logic       alu_shift_dbl,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       done,
  output logic [7:0] res,
  output logic [3:0] flags
);
  typedef enum logic [1:0] {IDLE, SHIFT, HIGH, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_q;
  logic [7:0] b_q;
  logic c_q, cy_q, is_left, is_swap, si, go;
  assign go = !alu_busy;
  assign is_swap = op_q == 3'b111;
  assign is_left = op_q == 3'b000 || op_q == 3'b010 || op_q == 3'b100;
  // shift-in: rotates feed back the outgoing bit, RL/RR feed the carry, SRA keeps the sign
  assign si = (op_q == 3'b000 || op_q == 3'b101) ? b_q[7] :
              (op_q == 3'b001) ? b_q[0] :
              (op_q == 3'b010 || op_q == 3'b011) ? c_q : 1'b0;
  // alu_* are only driven on a non-stalled cycle so a busy cycle never reloads the latches
  always_comb begin
    state_n = state;
    ack = 1'b0;
    done = 1'b0;
    alu_op = 8'h00;
    alu_si = 1'b0;
    alu_sh = 2'b00;
    alu_oe = 2'b00;
    alu_ld = 1'b0;
    alu_l = 1'b0;
    alu_h = 1'b0;
    case (state)
      IDLE: begin
        ack = req & go;
        state_n = ack ? SHIFT : IDLE;
      end
      SHIFT: if (go) begin
        alu_op = b_q;
        alu_si = si;
        alu_sh = is_swap ? 2'b11 : is_left ? 2'b01 : 2'b10;
        alu_oe = 2'b01;
        alu_ld = 1'b1;
        alu_l = 1'b1;
        state_n = HIGH;
      end
      HIGH: if (go) begin
        alu_oe = 2'b10;
        alu_h = 1'b1;
        state_n = DONE;
      end
      default: begin
        done = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      op_q <= 3'b000;
      b_q <= 8'h00;
      c_q <= 1'b0;
      cy_q <= 1'b0;
      res <= 8'h00;
      flags <= 4'h0;
    end else begin
      state <= state_n;
      if (ack) begin
        op_q <= req_op;
        b_q <= req_b;
        c_q <= req_c;
        res <= 8'h00;
        flags <= 4'h0;
      end
      if (state == SHIFT && go)
        cy_q <= is_swap ? 1'b0 : is_left ? alu_shift_dbh : alu_shift_dbl;
      if (state == HIGH && go) begin
        res <= alu_result;
        flags <= {alu_zero, 2'b00, cy_q};
      end
      if (state == DONE && !HOLD_RESULT) begin
        res <= 8'h00;
        flags <= 4'h0;
      end
    end
  end
endmodule
